// File: rtl/fm_demod_top_if.sv
// Streaming handshake bundle of the FM quadrature demodulator: sample push side
// and FWFT result pop side.
interface fm_demod_top_if #(
    parameter int DATA_WIDTH = 32
);
    logic signed [DATA_WIDTH-1:0] real_in;
    logic signed [DATA_WIDTH-1:0] imag_in;
    logic                         in_fifo_wr_en;
    logic                         out_fifo_rd_en;
    logic signed [DATA_WIDTH-1:0] data_out;
    logic                         in_fifos_full;
    logic                         out_fifo_empty;

    modport master (
        output real_in, imag_in, in_fifo_wr_en, out_fifo_rd_en,
        input  data_out, in_fifos_full, out_fifo_empty
    );

    modport slave (
        input  real_in, imag_in, in_fifo_wr_en, out_fifo_rd_en,
        output data_out, in_fifos_full, out_fifo_empty
    );
endinterface

// File: rtl/fm_demod_top.sv
// FM quadrature demodulator: input sample FIFOs, 4-state MULT/ATAN/GAIN sequencer
// and an FWFT result FIFO.
module fm_demod_top #(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 16,
    parameter int BITS       = 10,
    parameter int GAIN       = 758,
    parameter int QUAD1      = 804,
    parameter int QUAD3      = 2412
) (
    input logic           clk,
    input logic           reset,
    fm_demod_top_if.slave bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = 2 * DATA_WIDTH;
    localparam logic [AW:0]                  DEPTH_C = (AW+1)'(FIFO_DEPTH);
    localparam logic signed [PW-1:0]         QUANT_W = PW'(1 << BITS);
    localparam logic signed [PW-1:0]         DQ_BIAS = PW'((1 << BITS) - 1);
    localparam logic signed [PW-1:0]         GAIN_W  = PW'(GAIN);
    localparam logic signed [PW-1:0]         QUAD1_W = PW'(QUAD1);
    localparam logic signed [DATA_WIDTH-1:0] QUAD1_D = DATA_WIDTH'(QUAD1);
    localparam logic signed [DATA_WIDTH-1:0] QUAD3_D = DATA_WIDTH'(QUAD3);

    typedef enum logic [1:0] {S_IDLE, S_MULT, S_ATAN, S_GAIN} state_t;

    // Dequantize with truncation toward zero: negative values are biased before the shift.
    function automatic logic signed [DATA_WIDTH-1:0] dq(input logic signed [PW-1:0] x);
        logic signed [PW-1:0] biased;
        biased = x[PW-1] ? x + DQ_BIAS : x;
        return DATA_WIDTH'(biased >>> BITS);
    endfunction

    function automatic logic signed [DATA_WIDTH-1:0] qarctan(
        input logic signed [DATA_WIDTH-1:0] y,
        input logic signed [DATA_WIDTH-1:0] x
    );
        logic signed [PW-1:0]         xw;
        logic signed [PW-1:0]         ay;
        logic signed [PW-1:0]         q;
        logic signed [DATA_WIDTH-1:0] angle;
        xw = PW'(x);
        ay = (y[DATA_WIDTH-1] ? -PW'(y) : PW'(y)) + PW'(1);
        if (!x[DATA_WIDTH-1]) begin
            q     = ((xw - ay) * QUANT_W) / (xw + ay);
            angle = QUAD1_D - dq(QUAD1_W * q);
        end else begin
            q     = ((xw + ay) * QUANT_W) / (ay - xw);
            angle = QUAD3_D - dq(QUAD1_W * q);
        end
        if (y[DATA_WIDTH-1]) angle = -angle;
        return angle;
    endfunction

    state_t state, state_next;

    // Real and imag storage share one set of pointers so they can never drift apart.
    logic signed [DATA_WIDTH-1:0] real_mem [FIFO_DEPTH];
    logic signed [DATA_WIDTH-1:0] imag_mem [FIFO_DEPTH];
    logic [AW-1:0] in_wr_ptr, in_rd_ptr;
    logic [AW:0]   in_count;
    logic          in_push, in_pop, in_full, in_empty;

    logic signed [DATA_WIDTH-1:0] out_mem [FIFO_DEPTH];
    logic [AW-1:0] out_wr_ptr, out_rd_ptr;
    logic [AW:0]   out_count;
    logic          out_push, out_pop, out_full, out_empty;

    logic signed [DATA_WIDTH-1:0] real_prev, imag_prev;
    logic signed [DATA_WIDTH-1:0] cur_real_p0, cur_imag_p0;
    logic signed [DATA_WIDTH-1:0] r_p1, i_p1;
    logic signed [DATA_WIDTH-1:0] angle_p2;

    assign in_full   = (in_count == DEPTH_C);
    assign in_empty  = (in_count == '0);
    assign out_full  = (out_count == DEPTH_C);
    assign out_empty = (out_count == '0);

    assign in_push  = bus.in_fifo_wr_en && !in_full;
    assign in_pop   = (state == S_IDLE) && !in_empty && !out_full;
    assign out_push = (state == S_GAIN);
    assign out_pop  = bus.out_fifo_rd_en && !out_empty;

    assign bus.in_fifos_full  = in_full;
    assign bus.out_fifo_empty = out_empty;
    assign bus.data_out       = out_empty ? '0 : out_mem[out_rd_ptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            in_wr_ptr  <= '0;
            in_rd_ptr  <= '0;
            in_count   <= '0;
            out_wr_ptr <= '0;
            out_rd_ptr <= '0;
            out_count  <= '0;
            real_prev  <= '0;
            imag_prev  <= '0;
        end else begin
            state <= state_next;
            if (in_push)  in_wr_ptr  <= in_wr_ptr + 1'b1;
            if (in_pop)   in_rd_ptr  <= in_rd_ptr + 1'b1;
            if (out_push) out_wr_ptr <= out_wr_ptr + 1'b1;
            if (out_pop)  out_rd_ptr <= out_rd_ptr + 1'b1;
            case ({in_push, in_pop})
                2'b10:   in_count <= in_count + 1'b1;
                2'b01:   in_count <= in_count - 1'b1;
                default: in_count <= in_count;
            endcase
            case ({out_push, out_pop})
                2'b10:   out_count <= out_count + 1'b1;
                2'b01:   out_count <= out_count - 1'b1;
                default: out_count <= out_count;
            endcase
            if (state == S_MULT) begin
                real_prev <= cur_real_p0;
                imag_prev <= cur_imag_p0;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (in_pop) state_next = S_MULT;
            S_MULT:  state_next = S_ATAN;
            S_ATAN:  state_next = S_GAIN;
            S_GAIN:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (in_push) begin
            real_mem[in_wr_ptr] <= bus.real_in;
            imag_mem[in_wr_ptr] <= bus.imag_in;
        end
        // p0: sample popped from the input FIFO
        if (in_pop) begin
            cur_real_p0 <= real_mem[in_rd_ptr];
            cur_imag_p0 <= imag_mem[in_rd_ptr];
        end
        // p1: conjugate product with the previous sample
        if (state == S_MULT) begin
            r_p1 <= dq(PW'(real_prev) * PW'(cur_real_p0)) - dq(-PW'(imag_prev) * PW'(cur_imag_p0));
            i_p1 <= dq(PW'(real_prev) * PW'(cur_imag_p0)) + dq(-PW'(imag_prev) * PW'(cur_real_p0));
        end
        // p2: phase difference
        if (state == S_ATAN) angle_p2 <= qarctan(i_p1, r_p1);
        // p3: gain applied on the way into the result FIFO
        if (out_push) out_mem[out_wr_ptr] <= dq(GAIN_W * PW'(angle_p2));
    end
endmodule

// File: tb/tb_fm_demod_top.sv
// Directed bench for fm_demod_top: hand-computed vectors plus a reference-model
// scoreboard for the long streams.
module tb_fm_demod_top;
    logic clk;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    int   exp_q[$];
    int   prev_r = 0;
    int   prev_i = 0;
    bit   acc;
    int   acc_cnt;
    bit   saw_full;
    int   lat;
    int   sent;
    int   cyc;

    fm_demod_top_if #(.DATA_WIDTH(32)) bus ();

    fm_demod_top dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    function automatic int dq_m(input longint x);
        return int'(x / 64'sd1024);
    endfunction

    function automatic int model(input int pr, input int pi, input int cr, input int ci);
        int     r, i, angle;
        longint x, ay, q;
        r  = dq_m(longint'(pr) * ci * 0 + longint'(pr) * cr) - dq_m(-longint'(pi) * ci);
        i  = dq_m(longint'(pr) * ci) + dq_m(-longint'(pi) * cr);
        x  = r;
        ay = ((i < 0) ? -longint'(i) : longint'(i)) + 1;
        if (r >= 0) begin
            q     = ((x - ay) * 1024) / (x + ay);
            angle = 804 - dq_m(804 * q);
        end else begin
            q     = ((x + ay) * 1024) / (ay - x);
            angle = 2412 - dq_m(804 * q);
        end
        if (i < 0) angle = -angle;
        return dq_m(758 * longint'(angle));
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, expv);
        end
    endtask

    // Called at a falling edge; drives one write cycle and records it if accepted.
    task automatic push(input int re, input int im, input bit use_hand, input int hand, output bit accepted);
        bus.real_in       = re;
        bus.imag_in       = im;
        bus.in_fifo_wr_en = 1'b1;
        accepted = !bus.in_fifos_full;
        if (accepted) begin
            exp_q.push_back(use_hand ? hand : model(prev_r, prev_i, re, im));
            prev_r = re;
            prev_i = im;
        end
        @(negedge clk);
        bus.in_fifo_wr_en = 1'b0;
    endtask

    task automatic pop(input string tag);
        int k = 0;
        while (bus.out_fifo_empty && k < 60) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_avail"}, {31'd0, bus.out_fifo_empty}, 32'd0);
        if (!bus.out_fifo_empty) begin
            if (exp_q.size() > 0) check(tag, bus.data_out, exp_q.pop_front());
            else check({tag, "_spurious"}, bus.data_out, 32'hDEAD_BEEF);
            bus.out_fifo_rd_en = 1'b1;
            @(negedge clk);
            bus.out_fifo_rd_en = 1'b0;
        end
    endtask

    int t2_re  [6] = '{32'h400, 32'h0,   32'h400,      32'h0,        32'h400, 32'hFFFFFC00};
    int t2_im  [6] = '{32'h0,   32'h400, 32'h0,        32'hFFFFFC00, 32'h0,   32'h0};
    int t2_exp [6] = '{32'h1,   32'h4A6, 32'hFFFFFB5A, 32'hFFFFFB5A, 32'h4A6, 32'h94B};

    initial begin
        reset              = 1'b0;
        bus.real_in        = '0;
        bus.imag_in        = '0;
        bus.in_fifo_wr_en  = 1'b0;
        bus.out_fifo_rd_en = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_in_full", {31'd0, bus.in_fifos_full}, 32'd0);
        check("rst_out_empty", {31'd0, bus.out_fifo_empty}, 32'd1);
        check("rst_data_out", bus.data_out, 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // First sample with zero history, latency measured from the write edge
        bus.real_in       = 32'h400;
        bus.imag_in       = 32'h0;
        bus.in_fifo_wr_en = 1'b1;
        @(posedge clk);
        #1 bus.in_fifo_wr_en = 1'b0;
        lat = 0;
        while (bus.out_fifo_empty && lat < 8) begin
            @(posedge clk);
            #1 lat++;
        end
        check("t1_latency_le6", {31'd0, (lat <= 6)}, 32'd1);
        check("t1_data", bus.data_out, 32'h0000_04A6);
        @(negedge clk);
        bus.out_fifo_rd_en = 1'b1;
        @(negedge clk);
        bus.out_fifo_rd_en = 1'b0;
        check("t1_empty_after_pop", {31'd0, bus.out_fifo_empty}, 32'd1);
        prev_r = 32'h400;
        prev_i = 0;

        // Quarter-turn rotations, including the truncation-toward-zero case
        for (int k = 0; k < 6; k++) push(t2_re[k], t2_im[k], 1'b1, t2_exp[k], acc);
        for (int k = 0; k < 6; k++) pop($sformatf("t2_res%0d", k));
        check("t2_empty", {31'd0, bus.out_fifo_empty}, 32'd1);

        // Back-to-back writes with no reads: both FIFOs fill, extra writes drop
        acc_cnt  = 0;
        saw_full = 1'b0;
        for (int k = 0; k < 100; k++) begin
            push((k * 613) % 4096 - 2048, (k * 389 + 100) % 4096 - 2048, 1'b0, 0, acc);
            if (acc) acc_cnt++;
            if (bus.in_fifos_full) saw_full = 1'b1;
        end
        check("t3_saw_full", {31'd0, saw_full}, 32'd1);
        check("t3_accepted", acc_cnt, 32);
        check("t3_in_full", {31'd0, bus.in_fifos_full}, 32'd1);
        for (int k = 0; k < 4; k++) begin
            push(32'h7FFF_0000 + k, 32'h1234, 1'b0, 0, acc);
            check("t6_wr_while_full", {31'd0, acc}, 32'd0);
        end
        for (int k = 0; k < 32; k++) pop($sformatf("t3_drain%0d", k));
        check("t3_out_empty", {31'd0, bus.out_fifo_empty}, 32'd1);
        check("t3_in_not_full", {31'd0, bus.in_fifos_full}, 32'd0);

        // Read while empty: nothing changes
        bus.out_fifo_rd_en = 1'b1;
        repeat (3) @(negedge clk);
        bus.out_fifo_rd_en = 1'b0;
        check("t6_rd_empty_flag", {31'd0, bus.out_fifo_empty}, 32'd1);
        check("t6_rd_empty_data", bus.data_out, 32'd0);

        // Continuous writes, each result read as soon as it appears
        sent = 0;
        cyc  = 0;
        while ((sent < 40 || exp_q.size() > 0) && cyc < 1000) begin
            bus.in_fifo_wr_en  = (sent < 40);
            bus.real_in        = (sent * 977) % 3000 - 1500;
            bus.imag_in        = (sent * 541 + 7) % 3000 - 1500;
            bus.out_fifo_rd_en = !bus.out_fifo_empty;
            if (bus.in_fifo_wr_en && !bus.in_fifos_full) begin
                exp_q.push_back(model(prev_r, prev_i, bus.real_in, bus.imag_in));
                prev_r = bus.real_in;
                prev_i = bus.imag_in;
                sent++;
            end
            if (!bus.out_fifo_empty) begin
                if (exp_q.size() > 0) check("t4_stream", bus.data_out, exp_q.pop_front());
                else check("t4_spurious", bus.data_out, 32'hDEAD_BEEF);
            end
            @(negedge clk);
            cyc++;
        end
        bus.in_fifo_wr_en  = 1'b0;
        bus.out_fifo_rd_en = 1'b0;
        check("t4_all_sent", sent, 40);
        check("t4_queue_drained", exp_q.size(), 0);
        repeat (8) @(negedge clk);
        check("t4_no_extra", {31'd0, bus.out_fifo_empty}, 32'd1);

        // Reset in the middle of a stream
        for (int k = 0; k < 3; k++) push(32'h300 + k, 32'h155 * k, 1'b0, 0, acc);
        repeat (2) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("t5_rst_in_full", {31'd0, bus.in_fifos_full}, 32'd0);
        check("t5_rst_out_empty", {31'd0, bus.out_fifo_empty}, 32'd1);
        check("t5_rst_data", bus.data_out, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        exp_q.delete();
        prev_r = 0;
        prev_i = 0;
        repeat (6) @(negedge clk);
        check("t5_no_leftover", {31'd0, bus.out_fifo_empty}, 32'd1);
        push(32'h7ABC, 32'h1234, 1'b1, 32'h0000_04A6, acc);
        pop("t5_first_after_reset");
        repeat (6) @(negedge clk);
        check("t5_empty_end", {31'd0, bus.out_fifo_empty}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
